led_sequencer: RTL
==================

# led_sequencer

Multi-channel, parametrised LED colour sequencer for the board's status RGB LEDs, replacing the single-channel button-stepped colour cycler. Each channel steps a colour code through a configurable range, either manually on button presses or automatically from a shared prescaler, with forward-wrap and ping-pong modes. It sits between the debounced button inputs and the LED driver pins.

## Interface
- `WIDTH`, default 3: colour code width per channel.
- `N_CH`, default 2: number of independent channels.
- `MIN_COL`, default 1: lowest legal colour code. Constraint: 0 < `MIN_COL` < `MAX_COL`.
- `MAX_COL`, default 6: highest legal colour code. Constraint: `MAX_COL` < 2^`WIDTH`.
- `PRESCALE`, default 4: auto-advance period in clk cycles. Must be ≥ 1.
- `clk`, in, 1: clock. Everything is sampled on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `button`, in, `N_CH`: per-channel button level. Bit i belongs to channel i.
- `mode`, in, 2: global mode. 00 = manual, 01 = auto-forward, 10 = auto-ping-pong, 11 = hold.
- `colour`, out, `N_CH*WIDTH`: channel i occupies bits `[i*WIDTH +: WIDTH]`. Registered.
- `wrap`, out, `N_CH`: one-cycle pulse per channel on a range wrap or a direction reversal. Registered.

## Operation
- Reset values:
  - every `colour` field = 0;
  - `wrap` = 0;
  - button history registers = 0;
  - prescaler = 0;
  - every direction flag = up.
- Normalisation has the highest priority after reset. If a channel's colour is < `MIN_COL` or > `MAX_COL`, it loads `MIN_COL` on the next edge, whatever the mode or button. `wrap` stays 0 for that channel on that edge.
- Edge detect: `press[i] = button[i] & ~btn_q[i]`, where `btn_q` is the previous cycle's sampled button. A held button therefore advances a channel exactly once.
- Manual (00):
  - on `press[i]`, colour+1;
  - at `MAX_COL` the next step goes to `MIN_COL` and `wrap[i]` pulses;
  - without a press, colour holds.
- Auto-forward (01): every channel steps as in manual on each prescaler tick. Buttons are ignored.
- Auto-ping-pong (10):
  - on each tick, step +1 when dir = up and −1 when dir = down;
  - reaching `MAX_COL` flips dir to down, reaching `MIN_COL` flips dir to up;
  - the tick that lands on an endpoint also pulses `wrap[i]`;
  - buttons are ignored.
- Hold (11): colours are frozen. Normalisation still applies.
- Prescaler behaviour:
  - counts 0..`PRESCALE`−1 only while mode is 01 or 10;
  - tick = count == `PRESCALE`−1;
  - is forced to 0 in modes 00 and 11.
- Direction flags are forced to up in every mode except 10. Entering 10 therefore always starts upward.
- All arithmetic is `WIDTH`-bit. Range checks are done before the increment, so overflow cannot occur.
- A mode change takes effect on the edge where the new mode is sampled. A press sampled while mode ≠ 00 is discarded, but `btn_q` is still updated.

## Timing
- Manual latency: a button rising edge sampled at edge k updates `colour` at edge k, visible after k. With `LED_SEQ_SYNC_EN` defined it updates at edge k+2.
- Auto mode: the first step happens `PRESCALE` edges after entering 01 or 10. After that there is one step every `PRESCALE` edges.
- `wrap` is high for exactly the one cycle after the stepping edge.
- After reset deassertion, the first edge normalises every channel from 0 to `MIN_COL`.
- Reset asserted mid-sequence clears all state immediately, without waiting for a clock edge.

## Configuration
- `LED_SEQ_SYNC_EN`:
  - **Defined:** each `button` bit passes through a two-flop synchroniser (reset to 0) before edge detection. Manual latency is 2 extra cycles.
  - **Undefined:** `button` feeds the edge detector directly. Latency is as stated in Timing.

## Test plan
- Reset release, mode=00, `WIDTH`=3, `MIN_COL`=1, `MAX_COL`=6 -> both channels read 0, then 1 after the first edge; `wrap`=0.
- Manual: 6 separate single-cycle presses on ch0, ch1 idle -> ch0 goes 2,3,4,5,6,1 with `wrap[0]` pulsed on the 6→1 step; ch1 stays at 1.
- Manual held press: `button[0]` high for 10 cycles -> ch0 advances exactly once, 1→2.
- Auto-forward, `PRESCALE`=4 -> colour advances on every 4th edge; the 6→1 step pulses `wrap`; button presses have no effect.
- Ping-pong from 1 -> sequence 2,3,4,5,6,5,4,3,2,1,2 with `wrap` pulsed on arriving at 6 and at 1. Switching to 11 mid-sequence freezes the value.
- Reset asserted while ch0=4 in mode 10 -> colour reads 0 immediately, dir = up, prescaler = 0. After release, ch0 goes to 1 and then steps upward.

Source files
------------

// File: rtl/led_sequencer_if.sv
// Button/mode inputs and colour/wrap outputs of the LED colour sequencer.
interface led_sequencer_if #(
  parameter int WIDTH = 3,
  parameter int N_CH  = 2
);
  logic [N_CH-1:0]       button;
  logic [1:0]            mode;
  logic [N_CH*WIDTH-1:0] colour;
  logic [N_CH-1:0]       wrap;

  modport master (output button, mode, input colour, wrap);
  modport slave  (input button, mode, output colour, wrap);
endinterface

// File: rtl/led_sequencer.sv
// Multi-channel LED colour sequencer: manual, auto-forward, ping-pong and hold modes.
// Optional LED_SEQ_SYNC_EN adds a two-flop synchroniser on each button bit.
module led_seq_lane #(
  parameter int WIDTH   = 3,
  parameter int MIN_COL = 1,
  parameter int MAX_COL = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             press,
  input  logic             tick,
  output logic [WIDTH-1:0] colour,
  output logic             wrap
);
  typedef enum logic [1:0] {M_MANUAL = 2'b00, M_FWD = 2'b01, M_PP = 2'b10, M_HOLD = 2'b11} mode_e;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_COL);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COL);

  mode_e            m;
  dir_e             dir;
  logic             in_range, adv, go_up;
  logic [WIDTH-1:0] nxt;

  assign m        = mode_e'(mode);
  assign in_range = (colour >= MINV) && (colour <= MAXV);
  assign adv      = (m == M_MANUAL && press) || (m == M_FWD && tick);

  // Ping-pong target; an upward lane parked on MAX (entered 10 there) turns around.
  always_comb begin
    go_up = (dir == UP && colour != MAXV) || colour == MINV;
    nxt   = go_up ? colour + WIDTH'(1) : colour - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour <= '0;
      wrap   <= 1'b0;
      dir    <= UP;
    end else begin
      wrap <= 1'b0;
      if (m != M_PP) dir <= UP;
      if (!in_range) begin
        colour <= MINV;
      end else if (adv) begin
        if (colour == MAXV) begin
          colour <= MINV;
          wrap   <= 1'b1;
        end else begin
          colour <= colour + WIDTH'(1);
        end
      end else if (m == M_PP && tick) begin
        colour <= nxt;
        if (nxt == MAXV)      dir <= DOWN;
        else if (nxt == MINV) dir <= UP;
        else                  dir <= go_up ? UP : DOWN;
        wrap <= (nxt == MAXV) || (nxt == MINV) || (go_up != (dir == UP));
      end
    end
  end
endmodule

module led_sequencer #(
  parameter int WIDTH    = 3,
  parameter int N_CH     = 2,
  parameter int MIN_COL  = 1,
  parameter int MAX_COL  = 6,
  parameter int PRESCALE = 4
) (
  input logic          clk,
  input logic          rst,
  led_sequencer_if.slave bus
);
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [N_CH-1:0]            btn_s, btn_q, press;
  logic [N_CH-1:0][WIDTH-1:0] col;
  logic [N_CH-1:0]            wrp;
  logic [CW-1:0]              cnt;
  logic                       auto_m, tick;

`ifdef LED_SEQ_SYNC_EN
  logic [N_CH-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.button;
      sync2 <= sync1;
    end
  end
  assign btn_s = sync2;
`else
  assign btn_s = bus.button;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn_s;
  end
  assign press = btn_s & ~btn_q;

  // Shared prescaler only runs in the auto modes so each entry starts a fresh period.
  assign auto_m = (bus.mode == 2'b01) || (bus.mode == 2'b10);
  assign tick   = auto_m && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (!auto_m) cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    led_seq_lane #(.WIDTH(WIDTH), .MIN_COL(MIN_COL), .MAX_COL(MAX_COL)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .mode   (bus.mode),
      .press  (press[i]),
      .tick   (tick),
      .colour (col[i]),
      .wrap   (wrp[i])
    );
  end

  assign bus.colour = col;
  assign bus.wrap   = wrp;
endmodule
